// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults, load-size encodings
// and the writeback write-once FSM states.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'b00,
    WB_WRITE = 2'b01,
    WB_HELD  = 2'b10
  } wb_state_t;

endpackage

// File: rtl/wb_load_ext.sv
// Little-endian load lane extraction with sign/zero extension.
// Purely combinational; sits in front of the MEM/WB register.
module wb_load_ext
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    ext = rdata;
    case (size)
      LD_BYTE: ext = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
      LD_HALF: ext = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
      default: ext = rdata;  // LD_WORD and the unused 2'b11 encoding
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage with a write-once FSM.
// Optional retired-instruction counter enabled by WB_RETIRE_CNT_EN.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic              mem_MemtoReg,
  input  logic [REG_AW-1:0] mem_Wreg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_ld_size,
  input  logic              mem_ld_unsigned,
  output logic              RegWrite,
  output logic [REG_AW-1:0] Wreg,
  output logic [DATA_W-1:0] Wdata,
  output logic              wb_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  wb_state_t         state_reg, state_next;
  logic [REG_AW-1:0] wreg_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              valid_reg;
  logic [31:0]       load_ext;
  logic [DATA_W-1:0] data_sel;
  logic              intent;

  wb_load_ext u_load_ext (
    .rdata       (mem_rdata),
    .addr        (mem_alu_result[1:0]),
    .size        (mem_ld_size),
    .ld_unsigned (mem_ld_unsigned),
    .ext         (load_ext)
  );

  assign data_sel = mem_MemtoReg ? load_ext : mem_alu_result;
  assign intent   = mem_valid & mem_RegWrite & (mem_Wreg != '0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= WB_IDLE;
    else     state_reg <= state_next;
  end

  // A stalled WRITE drops to HELD so the regfile sees exactly one write.
  always_comb begin
    state_next = state_reg;
    if (flush)
      state_next = WB_IDLE;
    else if (stall)
      state_next = (state_reg == WB_IDLE) ? WB_IDLE : WB_HELD;
    else
      state_next = intent ? WB_WRITE : WB_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wreg_reg  <= '0;
      wdata_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (!stall) begin
        wreg_reg  <= mem_Wreg;
        wdata_reg <= data_sel;
      end
      if (flush)
        valid_reg <= 1'b0;
      else if (!stall)
        valid_reg <= mem_valid;
    end
  end

  assign RegWrite = (state_reg == WB_WRITE);
  assign Wreg     = wreg_reg;
  assign Wdata    = wdata_reg;
  assign wb_valid = valid_reg;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_reg <= 32'd0;
    else if (!stall && valid_reg)
      cnt_reg <= cnt_reg + 32'd1;
  end

  assign retire_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a transaction-level model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_RegWrite = 1'b0;
  logic        mem_MemtoReg = 1'b0;
  logic [3:0]  mem_Wreg = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_ld_size = '0;
  logic        mem_ld_unsigned = 1'b0;
  logic        RegWrite;
  logic [3:0]  Wreg;
  logic [31:0] Wdata;
  logic        wb_valid;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .mem_valid       (mem_valid),
    .mem_RegWrite    (mem_RegWrite),
    .mem_MemtoReg    (mem_MemtoReg),
    .mem_Wreg        (mem_Wreg),
    .mem_alu_result  (mem_alu_result),
    .mem_rdata       (mem_rdata),
    .mem_ld_size     (mem_ld_size),
    .mem_ld_unsigned (mem_ld_unsigned),
    .RegWrite        (RegWrite),
    .Wreg            (Wreg),
    .Wdata           (Wdata),
    .wb_valid        (wb_valid)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt      (retire_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the writeback stage must present, derived from the rules.
  logic        m_ready = 1'b0;
  logic        m_valid, m_rw;
  logic [3:0]  m_wreg;
  logic [31:0] m_wdata, m_cnt;

  function automatic logic [31:0] model_ext(input logic [31:0] rd, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'b10) begin
      v = (rd >> (int'(a) * 8)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (int'(a[1]) * 16)) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_rw = 0; m_wreg = 0; m_wdata = 0; m_cnt = 0;
    end else begin
      if (!stall && m_valid) m_cnt = m_cnt + 1;
      if (!stall) begin
        m_wreg  = mem_Wreg;
        m_wdata = mem_MemtoReg ? model_ext(mem_rdata, mem_alu_result[1:0], mem_ld_size, mem_ld_unsigned)
                               : mem_alu_result;
      end
      if (flush) begin
        m_valid = 0; m_rw = 0;
      end else if (stall) begin
        m_rw = 0;  // the held instruction already had its single write cycle
      end else begin
        m_valid = mem_valid;
        m_rw    = mem_valid && mem_RegWrite && (mem_Wreg != 0);
      end
    end
    m_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("cmp_RegWrite", {31'd0, RegWrite}, {31'd0, m_rw});
      chk("cmp_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      chk("cmp_Wreg", {28'd0, Wreg}, {28'd0, m_wreg});
      chk("cmp_Wdata", Wdata, m_wdata);
`ifdef WB_RETIRE_CNT_EN
      chk("cmp_retire_cnt", retire_cnt, m_cnt);
`endif
    end
  end

  // Drive one MEM-stage slot at negedge, then return 1 after the capture edge.
  task automatic apply(input logic r, input logic st, input logic fl, input logic v,
                       input logic rw, input logic m2r, input logic [3:0] wr,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic [1:0] sz, input logic uns);
    @(negedge clk);
    rst = r; stall = st; flush = fl; mem_valid = v; mem_RegWrite = rw;
    mem_MemtoReg = m2r; mem_Wreg = wr; mem_alu_result = alu; mem_rdata = rd;
    mem_ld_size = sz; mem_ld_unsigned = uns;
    @(posedge clk);
    #1;
    $display("txn rst=%0b stall=%0b flush=%0b valid=%0b rw=%0b m2r=%0b wreg=%0d alu=%h rdata=%h size=%0d uns=%0b -> RegWrite=%0b Wreg=%0d Wdata=%h wb_valid=%0b",
             r, st, fl, v, rw, m2r, wr, alu, rd, sz, uns, RegWrite, Wreg, Wdata, wb_valid);
  endtask

  localparam logic [31:0] LDW = 32'h8001_FF7F;
  logic [31:0] cnt_snap;

  initial begin
    // Reset held two cycles while inputs show an active write
    apply(1, 0, 0, 1, 1, 0, 4'd5, 32'h1234_5678, 0, 2'b00, 0);
    apply(1, 0, 0, 1, 1, 0, 4'd5, 32'h1234_5678, 0, 2'b00, 0);
    chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_Wreg", {28'd0, Wreg}, 32'd0);
    chk("rst_Wdata", Wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire_cnt", retire_cnt, 32'd0);
`endif

    apply(0, 0, 0, 1, 1, 0, 4'd5, 32'h0002_34CF, 0, 2'b00, 0);
    chk("alu_RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("alu_Wreg", {28'd0, Wreg}, 32'd5);
    chk("alu_Wdata", Wdata, 32'h0002_34CF);

    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0100, LDW, 2'b10, 0);
    chk("lb_a0", Wdata, 32'h0000_007F);
    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0101, LDW, 2'b10, 0);
    chk("lb_a1", Wdata, 32'hFFFF_FFFF);
    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0102, LDW, 2'b01, 1);
    chk("lhu_a2", Wdata, 32'h0000_8001);
    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0102, LDW, 2'b01, 0);
    chk("lh_a2", Wdata, 32'hFFFF_8001);
    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0103, LDW, 2'b01, 0);
    chk("lh_a3", Wdata, 32'hFFFF_8001);
    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0103, LDW, 2'b10, 1);
    chk("lbu_a3", Wdata, 32'h0000_0080);
    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0102, LDW, 2'b00, 0);
    chk("lw", Wdata, LDW);
    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0101, LDW, 2'b11, 0);
    chk("lsize11", Wdata, LDW);
    apply(0, 0, 0, 1, 1, 1, 4'd3, 32'h0000_0102, 32'h0000_8000, 2'b01, 0);
    chk("lh_a2_low", Wdata, 32'h0000_0000);

    // r0 suppression
    cnt_snap = m_cnt;
    apply(0, 0, 0, 1, 1, 0, 4'd0, 32'h0005_4231, 0, 2'b00, 0);
    chk("r0_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
    apply(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 2'b00, 0);
    chk("r0_model_cnt", m_cnt, cnt_snap + 32'd2);
`ifdef WB_RETIRE_CNT_EN
    chk("r0_retire_cnt", retire_cnt, cnt_snap + 32'd2);
`endif

    // Stall: one write cycle for r9, contents held for three stalled edges
    apply(0, 0, 0, 1, 1, 0, 4'd9, 32'h0000_0099, 0, 2'b00, 0);
    chk("st_RegWrite0", {31'd0, RegWrite}, 32'd1);
    cnt_snap = m_cnt;
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 1, 1, 0, 4'd7, 32'hDEAD_BEEF, 0, 2'b00, 0);
      chk("st_RegWrite_held", {31'd0, RegWrite}, 32'd0);
      chk("st_Wdata_held", Wdata, 32'h0000_0099);
      chk("st_Wreg_held", {28'd0, Wreg}, 32'd9);
      chk("st_wb_valid_held", {31'd0, wb_valid}, 32'd1);
    end
    apply(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 2'b00, 0);
    chk("st_cnt_once", m_cnt, cnt_snap + 32'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("st_retire_cnt", retire_cnt, cnt_snap + 32'd1);
`endif

    // Flush during stall with a valid write on the inputs
    apply(0, 0, 0, 1, 1, 0, 4'd4, 32'h0000_0444, 0, 2'b00, 0);
    cnt_snap = m_cnt;
    apply(0, 1, 1, 1, 1, 0, 4'd6, 32'h0000_0666, 0, 2'b00, 0);
    chk("fl_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("fl_RegWrite", {31'd0, RegWrite}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("fl_retire_cnt", retire_cnt, cnt_snap);
`endif
    // Flush without stall
    apply(0, 0, 1, 1, 1, 0, 4'd6, 32'h0000_0666, 0, 2'b00, 0);
    chk("fl2_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("fl2_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Reset mid-stall discards the held write
    apply(0, 0, 0, 1, 1, 0, 4'd6, 32'h0000_0777, 0, 2'b00, 0);
    apply(0, 1, 0, 1, 1, 0, 4'd6, 32'h0000_0777, 0, 2'b00, 0);
    apply(1, 1, 0, 1, 1, 0, 4'd6, 32'h0000_0777, 0, 2'b00, 0);
    chk("rs_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rs_Wdata", Wdata, 32'd0);
    apply(0, 1, 0, 0, 0, 0, 4'd0, 0, 0, 2'b00, 0);
    chk("rs_RegWrite_after", {31'd0, RegWrite}, 32'd0);
    apply(0, 0, 0, 1, 1, 0, 4'd2, 32'h0000_0022, 0, 2'b00, 0);
    chk("rs_first_write", {31'd0, RegWrite}, 32'd1);
    apply(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 2'b00, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback stage of the 5-stage MIPS pipeline. Captures the memory-stage result on each rising clock edge and selects ALU result or load data, with byte/halfword lane extraction and sign/zero extension. Drives the register-file write port (`RegWrite`, `Wreg`, `Wdata`) for the following cycle. The register file commits on the falling edge, so the decode stage reads the new value in that same cycle.

## Interface
- `DATA_W`, 32: datapath width.
- `REG_AW`, 4: register address width (16 architectural registers, r0 hardwired zero).

- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold MEM/WB contents.
- `flush`  in  1  invalidate the instruction being captured.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_RegWrite`  in  1  instruction writes a register.
- `mem_MemtoReg`  in  1  1 = load data, 0 = ALU result.
- `mem_Wreg`  in  REG_AW  destination register.
- `mem_alu_result`  in  DATA_W  ALU result; also the load address.
- `mem_rdata`  in  DATA_W  raw word from data memory.
- `mem_ld_size`  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- `mem_ld_unsigned`  in  1  zero-extend instead of sign-extend.
- `RegWrite`  out  1  register-file write enable.
- `Wreg`  out  REG_AW  register-file write address.
- `Wdata`  out  DATA_W  register-file write data; also the forwarding source.
- `wb_valid`  out  1  stage holds a valid instruction.
- `retire_cnt`  out  32  retired-instruction count (only with the macro).

## Operation
- Capture at posedge when `stall`=0:
  - `wb_valid` <= `mem_valid & ~flush`.
  - Register `Wreg`, the write-enable intent, and the selected/extended data.
- Capture priority: `rst` > `flush` > `stall` > normal capture.
  - Flush during stall clears `wb_valid` and the intent.
- Data select:
  - `mem_MemtoReg`=0: `Wdata` = `mem_alu_result`.
  - `mem_MemtoReg`=1: `Wdata` = extended load data.
- Load extraction is little-endian, using `a` = `mem_alu_result[1:0]`:
  - Byte: lane `a`, i.e. bits [8a+7:8a].
  - Half: lane `a[1]`, i.e. bits [16a[1]+15:16a[1]]; `a[0]` is ignored.
  - Word: `a` is ignored.
  - Sign-extend unless `mem_ld_unsigned`=1.
- Write intent = `mem_valid & mem_RegWrite & (mem_Wreg != 0)`. Writes to r0 are always suppressed.
- One-shot write FSM:
  - States IDLE, WRITE, HELD.
  - Capture with intent → WRITE; capture without intent → IDLE.
  - In WRITE, `RegWrite`=1.
  - WRITE with `stall`=1 at posedge → HELD. `RegWrite`=0 and the contents are held, so each instruction writes exactly once.
  - Any capture from any state reloads per the intent.
  - Flush → IDLE.
- `retire_cnt` increments by 1 on every posedge where `stall`=0 and `wb_valid`=1. It wraps modulo 2^32.

## Timing
- Latency: MEM inputs at posedge N appear on `Wdata`/`RegWrite` during cycle N..N+1.
  - Register file commits at the negedge of that cycle.
  - Decode reads the value in the same cycle, so no WB→ID bypass is needed.
- `Wdata` is registered, not combinational from MEM inputs. This isolates memory read latency from the regfile write path.
- Reset values:
  - `RegWrite`=0, `Wreg`=0, `Wdata`=0, `wb_valid`=0, `retire_cnt`=0, FSM=IDLE.
- Reset mid-stall discards the held instruction; its write never occurs.
- `stall` and `flush` sample only at posedge and have no combinational path to outputs.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - `retire_cnt` port and 32-bit counter are present.
- `WB_RETIRE_CNT_EN` undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package `mips_pkg` holds:
  - Load-size encodings `LD_WORD`=2'b00, `LD_HALF`=2'b01, `LD_BYTE`=2'b10.
  - The WB FSM state enum.
  - `DATA_W`/`REG_AW` defaults.
- Sub-module `wb_load_ext` is purely combinational: `rdata`, `addr[1:0]`, `size`, `unsigned` → 32-bit extended value. It is instantiated before the pipeline register.

## Test plan
- Reset: assert `rst` 2 cycles with active inputs → all outputs 0, FSM IDLE; first valid ALU op after release writes on the following cycle.
- ALU writeback: `mem_Wreg`=5, `mem_alu_result`=0x000234CF, RegWrite=1, MemtoReg=0 → next cycle `RegWrite`=1, `Wreg`=5, `Wdata`=0x000234CF.
- Load extension with `mem_rdata`=0x8001FF7F:
  - Byte, addr[1:0]=0, signed → 0x0000007F.
  - Byte, addr[1:0]=1, signed → 0xFFFFFFFF.
  - Half, addr[1:0]=2, unsigned → 0x00008001.
  - Half, addr[1:0]=2, signed → 0xFFFF8001.
- r0 suppression: `mem_Wreg`=0, RegWrite=1, data 0x00054231 → `RegWrite` stays 0; `wb_valid`=1; `retire_cnt` +1.
- Stall: capture a write to r9, then hold `stall` 3 cycles → `RegWrite`=1 for exactly one cycle, then 0; `Wdata` is held; `retire_cnt` increments once after the stall drops.
- Flush with stall: `flush`=1 and `stall`=1 with a valid write on the inputs → next cycle `wb_valid`=0 and `RegWrite`=0; `retire_cnt` unchanged.
